// File: rtl/axi_crossbar_mst_port.sv
// Single-clock master-side crossbar port: per-channel 2-entry skid buffers, master ID tagging,
// outstanding read/write limiting and W gating on accepted AW bursts.

module axi_crossbar_mst_port #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_ID_W = 4,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned MST_ID_PFX_W = 2,
    parameter logic [MST_ID_PFX_W-1:0] MST_ID_PFX = 2'b01,
    parameter int unsigned MST_OSTD_NUM = 4,
    localparam int unsigned CNT_W = $clog2(MST_OSTD_NUM + 1),
    localparam int unsigned AWCH_W = AXI_ADDR_W + AXI_ID_W + 11,
    localparam int unsigned WCH_W = AXI_DATA_W * 9 / 8 + AXI_ID_W
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic                      i_awvalid,
    output logic                      i_awready,
    input  logic [AXI_ADDR_W-1:0]     i_awaddr,
    input  logic [3:0]                i_awlen,
    input  logic [2:0]                i_awsize,
    input  logic [1:0]                i_awburst,
    input  logic [AXI_ID_W-1:0]       i_awid,
    input  logic [1:0]                i_awlock,
    input  logic                      i_wvalid,
    output logic                      i_wready,
    input  logic                      i_wlast,
    input  logic [AXI_ID_W-1:0]       i_wid,
    input  logic [AXI_DATA_W-1:0]     i_wdata,
    input  logic [AXI_DATA_W/8-1:0]   i_wstrb,
    output logic                      i_bvalid,
    input  logic                      i_bready,
    output logic [AXI_ID_W-1:0]       i_bid,
    output logic [1:0]                i_bresp,
    input  logic                      i_arvalid,
    output logic                      i_arready,
    input  logic [AXI_ADDR_W-1:0]     i_araddr,
    input  logic [3:0]                i_arlen,
    input  logic [2:0]                i_arsize,
    input  logic [1:0]                i_arburst,
    input  logic [AXI_ID_W-1:0]       i_arid,
    input  logic [1:0]                i_arlock,
    output logic                      i_rvalid,
    input  logic                      i_rready,
    output logic [AXI_ID_W-1:0]       i_rid,
    output logic [1:0]                i_rresp,
    output logic [AXI_DATA_W-1:0]     i_rdata,
    output logic                      i_rlast,
    output logic                      o_awvalid,
    input  logic                      o_awready,
    output logic [AWCH_W-1:0]         o_awch,
    output logic                      o_wvalid,
    input  logic                      o_wready,
    output logic                      o_wlast,
    output logic [WCH_W-1:0]          o_wch,
    input  logic                      o_bvalid,
    output logic                      o_bready,
    input  logic [AXI_ID_W+1:0]       o_bch,
    output logic                      o_arvalid,
    input  logic                      o_arready,
    output logic [AWCH_W-1:0]         o_arch,
    input  logic                      o_rvalid,
    output logic                      o_rready,
    input  logic                      o_rlast,
    input  logic [AXI_DATA_W+AXI_ID_W+1:0] o_rch,
    output logic [CNT_W-1:0]          o_wr_ostd,
    output logic [CNT_W-1:0]          o_rd_ostd,
    output logic                      o_idle
);
    localparam int unsigned LOW_W = AXI_ID_W - MST_ID_PFX_W;
    localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(MST_OSTD_NUM);

    logic             rdy_en_q;
    logic [CNT_W-1:0] wr_ostd_q, wr_ostd_d, rd_ostd_q, rd_ostd_d, credit_q, credit_d;
    logic             aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
    logic             unused_id_bits;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        cnt_next = cnt;
        if (inc && !dec && cnt != OSTD_MAX) cnt_next = cnt + 1'b1;
        else if (dec && !inc && cnt != '0) cnt_next = cnt - 1'b1;
    endfunction

    // Holds every ready low until the first edge after reset release.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) rdy_en_q <= 1'b0;
        else      rdy_en_q <= 1'b1;
    end

    axi_crossbar_mst_port_skid #(.W(AWCH_W)) u_aw_skid (
        .clk_i(aclk), .rst_i(arst), .en_i(rdy_en_q && (wr_ostd_q != OSTD_MAX)),
        .in_valid_i(i_awvalid), .in_ready_o(i_awready),
        .in_data_i({i_awlock, i_awburst, i_awsize, i_awlen, MST_ID_PFX, i_awid[LOW_W-1:0], i_awaddr}),
        .out_valid_o(o_awvalid), .out_ready_i(o_awready), .out_data_o(o_awch));

    axi_crossbar_mst_port_skid #(.W(WCH_W + 1)) u_w_skid (
        .clk_i(aclk), .rst_i(arst), .en_i(rdy_en_q && (credit_q != '0)),
        .in_valid_i(i_wvalid), .in_ready_o(i_wready),
        .in_data_i({i_wlast, i_wstrb, i_wdata, MST_ID_PFX, i_wid[LOW_W-1:0]}),
        .out_valid_o(o_wvalid), .out_ready_i(o_wready), .out_data_o({o_wlast, o_wch}));

    axi_crossbar_mst_port_skid #(.W(AXI_ID_W + 2)) u_b_skid (
        .clk_i(aclk), .rst_i(arst), .en_i(rdy_en_q),
        .in_valid_i(o_bvalid), .in_ready_o(o_bready),
        .in_data_i({o_bch[AXI_ID_W+1:AXI_ID_W], {MST_ID_PFX_W{1'b0}}, o_bch[LOW_W-1:0]}),
        .out_valid_o(i_bvalid), .out_ready_i(i_bready), .out_data_o({i_bresp, i_bid}));

    axi_crossbar_mst_port_skid #(.W(AWCH_W)) u_ar_skid (
        .clk_i(aclk), .rst_i(arst), .en_i(rdy_en_q && (rd_ostd_q != OSTD_MAX)),
        .in_valid_i(i_arvalid), .in_ready_o(i_arready),
        .in_data_i({i_arlock, i_arburst, i_arsize, i_arlen, MST_ID_PFX, i_arid[LOW_W-1:0], i_araddr}),
        .out_valid_o(o_arvalid), .out_ready_i(o_arready), .out_data_o(o_arch));

    axi_crossbar_mst_port_skid #(.W(AXI_DATA_W + AXI_ID_W + 3)) u_r_skid (
        .clk_i(aclk), .rst_i(arst), .en_i(rdy_en_q),
        .in_valid_i(o_rvalid), .in_ready_o(o_rready),
        .in_data_i({o_rlast, o_rch[AXI_DATA_W+AXI_ID_W+1:AXI_ID_W], {MST_ID_PFX_W{1'b0}},
                    o_rch[LOW_W-1:0]}),
        .out_valid_o(i_rvalid), .out_ready_i(i_rready),
        .out_data_o({i_rlast, i_rdata, i_rresp, i_rid}));

    // Upper master ID bits are overwritten by the tag and never propagate.
    assign unused_id_bits = ^{i_awid[AXI_ID_W-1:LOW_W], i_arid[AXI_ID_W-1:LOW_W],
                              i_wid[AXI_ID_W-1:LOW_W], o_bch[AXI_ID_W-1:LOW_W],
                              o_rch[AXI_ID_W-1:LOW_W]};

    assign aw_hs     = i_awvalid && i_awready;
    assign w_last_hs = i_wvalid && i_wready && i_wlast;
    assign b_hs      = i_bvalid && i_bready;
    assign ar_hs     = i_arvalid && i_arready;
    assign r_last_hs = i_rvalid && i_rready && i_rlast;

    always_comb begin
        wr_ostd_d = cnt_next(wr_ostd_q, aw_hs, b_hs);
        rd_ostd_d = cnt_next(rd_ostd_q, ar_hs, r_last_hs);
        credit_d  = cnt_next(credit_q, aw_hs, w_last_hs);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ostd_q <= '0;
            rd_ostd_q <= '0;
            credit_q  <= '0;
        end else begin
            wr_ostd_q <= wr_ostd_d;
            rd_ostd_q <= rd_ostd_d;
            credit_q  <= credit_d;
        end
    end

    assign o_wr_ostd = wr_ostd_q;
    assign o_rd_ostd = rd_ostd_q;
    assign o_idle    = (wr_ostd_q == '0) && (rd_ostd_q == '0) && (credit_q == '0) &&
                       !o_awvalid && !o_wvalid && !i_bvalid && !o_arvalid && !i_rvalid;

    assert property (@(posedge aclk) disable iff (arst) !(b_hs && !aw_hs && (wr_ostd_q == '0)));
    assert property (@(posedge aclk) disable iff (arst) !(r_last_hs && !ar_hs && (rd_ostd_q == '0)));
endmodule

module axi_crossbar_mst_port_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic [W-1:0] mem_q [2];
    logic         wptr_q, rptr_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_ready_o  = en_i && (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_crossbar_mst_port.sv
// Scoreboard bench for axi_crossbar_mst_port: tasks queue expected beats, a negedge monitor
// pops and compares every handshake on the five channel outputs.

module tb_axi_crossbar_mst_port;
    logic        aclk = 1'b0;
    logic        arst = 1'b0;
    logic        i_awvalid = 0, i_awready;
    logic [31:0] i_awaddr = '0;
    logic [3:0]  i_awlen = '0;
    logic [2:0]  i_awsize = '0;
    logic [1:0]  i_awburst = '0;
    logic [3:0]  i_awid = '0;
    logic [1:0]  i_awlock = '0;
    logic        i_wvalid = 0, i_wready, i_wlast = 0;
    logic [3:0]  i_wid = '0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_bvalid, i_bready = 1;
    logic [3:0]  i_bid;
    logic [1:0]  i_bresp;
    logic        i_arvalid = 0, i_arready;
    logic [31:0] i_araddr = '0;
    logic [3:0]  i_arlen = '0;
    logic [2:0]  i_arsize = '0;
    logic [1:0]  i_arburst = '0;
    logic [3:0]  i_arid = '0;
    logic [1:0]  i_arlock = '0;
    logic        i_rvalid, i_rready = 1;
    logic [3:0]  i_rid;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        o_awvalid, o_awready = 1;
    logic [46:0] o_awch;
    logic        o_wvalid, o_wready = 1, o_wlast;
    logic [39:0] o_wch;
    logic        o_bvalid = 0, o_bready;
    logic [5:0]  o_bch = '0;
    logic        o_arvalid, o_arready = 1;
    logic [46:0] o_arch;
    logic        o_rvalid = 0, o_rready, o_rlast = 0;
    logic [37:0] o_rch = '0;
    logic [2:0]  o_wr_ostd, o_rd_ostd;
    logic        o_idle;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_aw[$], exp_w[$], exp_b[$], exp_ar[$], exp_r[$];
    logic [63:0] w_hold = '0;
    bit          w_hold_v = 0;

    axi_crossbar_mst_port #(
        .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32),
        .MST_ID_PFX_W(2), .MST_ID_PFX(2'b01), .MST_OSTD_NUM(4)
    ) dut (
        .aclk(aclk), .arst(arst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
        .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awid(i_awid), .i_awlock(i_awlock),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wid(i_wid),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bid(i_bid), .i_bresp(i_bresp),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arid(i_arid), .i_arlock(i_arlock),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rid(i_rid), .i_rresp(i_rresp),
        .i_rdata(i_rdata), .i_rlast(i_rlast),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
        .o_wr_ostd(o_wr_ostd), .o_rd_ostd(o_rd_ostd), .o_idle(o_idle)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=no_beat", name, act);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=no_handshake required=handshake", name);
    endtask

    // Monitor: compare every output handshake against the queued expectation.
    always @(negedge aclk) begin
        if (arst) begin
            w_hold_v = 0;
        end else begin
            if (w_hold_v)
                chk("w_stable", 64'({o_wvalid, o_wlast, o_wch}), 64'({1'b1, w_hold[40:0]}));
            w_hold_v = o_wvalid && !o_wready;
            w_hold   = 64'({o_wlast, o_wch});
            if (o_awvalid && o_awready) begin
                if (exp_aw.size() == 0) extra("aw_extra", 64'(o_awch));
                else chk("aw_payload", 64'(o_awch), exp_aw.pop_front());
            end
            if (o_wvalid && o_wready) begin
                if (exp_w.size() == 0) extra("w_extra", 64'({o_wlast, o_wch}));
                else chk("w_payload", 64'({o_wlast, o_wch}), exp_w.pop_front());
            end
            if (o_arvalid && o_arready) begin
                if (exp_ar.size() == 0) extra("ar_extra", 64'(o_arch));
                else chk("ar_payload", 64'(o_arch), exp_ar.pop_front());
            end
            if (i_bvalid && i_bready) begin
                if (exp_b.size() == 0) extra("b_extra", 64'({i_bresp, i_bid}));
                else chk("b_payload", 64'({i_bresp, i_bid}), exp_b.pop_front());
            end
            if (i_rvalid && i_rready) begin
                if (exp_r.size() == 0) extra("r_extra", 64'({i_rlast, i_rdata, i_rresp, i_rid}));
                else chk("r_payload", 64'({i_rlast, i_rdata, i_rresp, i_rid}), exp_r.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic present_aw(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
        i_awaddr = addr; i_awid = id; i_awlen = len;
        i_awsize = 3'd2; i_awburst = 2'b01; i_awlock = 2'b00; i_awvalid = 1;
        exp_aw.push_back(64'({2'b00, 2'b01, 3'd2, len, 2'b01, id[1:0], addr}));
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!i_awready && n < 100) begin cyc(1); n++; end
        if (n >= 100) timeout("aw");
        cyc(1);
        i_awvalid = 0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
        present_aw(addr, id, len);
        wait_aw();
    endtask

    task automatic present_ar(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len);
        i_araddr = addr; i_arid = id; i_arlen = len;
        i_arsize = 3'd2; i_arburst = 2'b01; i_arlock = 2'b00; i_arvalid = 1;
        exp_ar.push_back(64'({2'b00, 2'b01, 3'd2, len, 2'b01, id[1:0], addr}));
    endtask

    task automatic wait_ar(output int n);
        n = 0;
        while (!i_arready && n < 100) begin cyc(1); n++; end
        if (n >= 100) timeout("ar");
        cyc(1);
        i_arvalid = 0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id);
        int n;
        present_ar(addr, id, 4'd0);
        wait_ar(n);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic [3:0] id,
                          input logic last);
        int n = 0;
        i_wdata = data; i_wstrb = strb; i_wid = id; i_wlast = last; i_wvalid = 1;
        exp_w.push_back(64'({last, strb, data, 2'b01, id[1:0]}));
        while (!i_wready && n < 100) begin cyc(1); n++; end
        if (n >= 100) timeout("w");
        cyc(1);
        i_wvalid = 0;
    endtask

    task automatic send_b(input logic [3:0] id_ex, input logic [1:0] resp);
        int n = 0;
        o_bch = {resp, id_ex}; o_bvalid = 1;
        exp_b.push_back(64'({resp, 2'b00, id_ex[1:0]}));
        while (!o_bready && n < 100) begin cyc(1); n++; end
        if (n >= 100) timeout("b");
        cyc(1);
        o_bvalid = 0;
    endtask

    task automatic send_r(input logic [3:0] id_ex, input logic [31:0] data, input logic [1:0] resp,
                          input logic last);
        int n = 0;
        o_rch = {data, resp, id_ex}; o_rlast = last; o_rvalid = 1;
        exp_r.push_back(64'({last, data, resp, 2'b00, id_ex[1:0]}));
        while (!o_rready && n < 100) begin cyc(1); n++; end
        if (n >= 100) timeout("r");
        cyc(1);
        o_rvalid = 0;
    endtask

    initial begin
        int n;
        #1 arst = 1;
        #2;
        chk("rst_awready", 64'(i_awready), 64'd0);
        chk("rst_arready", 64'(i_arready), 64'd0);
        chk("rst_bready_sw", 64'(o_bready), 64'd0);
        chk("rst_rready_sw", 64'(o_rready), 64'd0);
        chk("rst_valids", 64'({o_awvalid, o_wvalid, o_arvalid, i_bvalid, i_rvalid}), 64'd0);
        chk("rst_counts", 64'({o_wr_ostd, o_rd_ostd}), 64'd0);
        chk("rst_idle", 64'(o_idle), 64'd1);
        #19 arst = 0;
        cyc(1);
        chk("rel_awready", 64'(i_awready), 64'd1);
        chk("rel_wready_nocredit", 64'(i_wready), 64'd0);
        chk("rel_rready_sw", 64'(o_rready), 64'd1);

        // Single write.
        chk("aw_idle_valid", 64'(o_awvalid), 64'd0);
        send_aw(32'h100, 4'h3, 4'd0);
        chk("aw_valid_latency", 64'(o_awvalid), 64'd1);
        chk("wr_ostd_one", 64'(o_wr_ostd), 64'd1);
        send_w(32'hDEAD_BEEF, 4'hF, 4'h3, 1'b1);
        send_b(4'h7, 2'b00);
        cyc(3);
        chk("wr_ostd_zero", 64'(o_wr_ostd), 64'd0);
        chk("idle_after_write", 64'(o_idle), 64'd1);

        // Read outstanding limit.
        for (int i = 0; i < 4; i++) send_ar(32'h1000 + 32'(i) * 32'h10, 4'(i));
        chk("rd_ostd_full", 64'(o_rd_ostd), 64'd4);
        chk("arready_at_limit", 64'(i_arready), 64'd0);
        present_ar(32'h2000, 4'hA, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ar5_blocked", 64'(i_arready), 64'd0);
            cyc(1);
        end
        chk("rd_ostd_held", 64'(o_rd_ostd), 64'd4);
        send_r(4'h5, 32'h1111_0001, 2'b00, 1'b1);
        wait_ar(n);
        chk("ar5_accept_latency", 64'(n), 64'd1);
        chk("rd_ostd_refill", 64'(o_rd_ostd), 64'd4);
        send_r(4'h4, 32'hAAAA_0000, 2'b01, 1'b0);
        cyc(3);
        chk("rd_nonlast_keeps", 64'(o_rd_ostd), 64'd4);
        for (int i = 0; i < 4; i++) send_r(4'hC, 32'h2222_0000 + 32'(i), 2'b00, 1'b1);
        cyc(4);
        chk("rd_ostd_drained", 64'(o_rd_ostd), 64'd0);

        // W gating.
        i_wdata = 32'h5555_0000; i_wstrb = 4'h3; i_wid = 4'h5; i_wlast = 0; i_wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            chk("w_gated", 64'(i_wready), 64'd0);
            cyc(1);
        end
        send_aw(32'h400, 4'h5, 4'd3);
        for (int i = 0; i < 4; i++) send_w(32'h5555_0000 + 32'(i), 4'h3, 4'h5, i == 3);
        chk("w_gated_after_last", 64'(i_wready), 64'd0);
        send_b(4'h5, 2'b00);
        cyc(4);
        chk("wr_ostd_after_gating", 64'(o_wr_ostd), 64'd0);

        // Switch-side backpressure on W.
        send_aw(32'h500, 4'h6, 4'd7);
        fork
            for (int i = 0; i < 40; i++) begin
                o_wready = ~o_wready;
                cyc(1);
            end
            for (int i = 0; i < 8; i++)
                send_w(32'hB000_0000 + 32'(i * 3), 4'(i + 1), 4'h6, i == 7);
        join
        o_wready = 1;
        cyc(4);
        chk("w_all_delivered", 64'(exp_w.size()), 64'd0);
        send_b(4'h6, 2'b00);
        cyc(4);

        // Simultaneous AW and B handshakes at wr_ostd=2.
        send_aw(32'h610, 4'h1, 4'd0);
        send_aw(32'h620, 4'h2, 4'd0);
        send_w(32'h6100_0000, 4'hF, 4'h1, 1'b1);
        send_w(32'h6200_0000, 4'hF, 4'h2, 1'b1);
        chk("wr_ostd_two", 64'(o_wr_ostd), 64'd2);
        i_bready = 0;
        send_b(4'h5, 2'b00);
        cyc(1);
        chk("b_waiting", 64'(i_bvalid), 64'd1);
        present_aw(32'h630, 4'h3, 4'd0);
        i_bready = 1;
        chk("aw_ready_simul", 64'(i_awready), 64'd1);
        cyc(1);
        i_awvalid = 0;
        chk("wr_ostd_simul", 64'(o_wr_ostd), 64'd2);
        send_w(32'h6300_0000, 4'hF, 4'h3, 1'b1);
        send_b(4'h6, 2'b01);
        send_b(4'h7, 2'b00);
        cyc(4);
        chk("wr_ostd_simul_drain", 64'(o_wr_ostd), 64'd0);

        // Reset pulse with two W beats buffered.
        o_wready = 0;
        send_aw(32'h700, 4'h0, 4'd3);
        send_w(32'h7000_0000, 4'hF, 4'h0, 1'b0);
        send_w(32'h7000_0001, 4'hF, 4'h0, 1'b0);
        chk("w_buffered", 64'(o_wvalid), 64'd1);
        #2 arst = 1;
        #1;
        chk("arst_wvalid", 64'(o_wvalid), 64'd0);
        chk("arst_counts", 64'({o_wr_ostd, o_rd_ostd}), 64'd0);
        chk("arst_idle", 64'(o_idle), 64'd1);
        chk("arst_wready", 64'(i_wready), 64'd0);
        exp_w.delete();
        #10 arst = 0;
        o_wready = 1;
        cyc(1);
        chk("post_rst_awready", 64'(i_awready), 64'd1);
        send_aw(32'h200, 4'h2, 4'd0);
        send_w(32'hCAFE_F00D, 4'h9, 4'h2, 1'b1);
        send_b(4'h6, 2'b10);
        cyc(4);
        chk("post_rst_wr_ostd", 64'(o_wr_ostd), 64'd0);
        chk("post_rst_idle", 64'(o_idle), 64'd1);

        chk("queues_empty", 64'(exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size()
                                + exp_r.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
